// File: rtl/async_fifo_frame_writer.sv
// Write-side frame producer for the dual-clock Gray-pointer FIFO: emits a
// {seq,len} header, the payload words and an XOR checksum trailer, never writing while full.
module async_fifo_frame_writer #(
    parameter int DSIZE = 16,
    parameter int LENW  = 8,
    localparam int SEQW = DSIZE - LENW
) (
    input  logic             wclk,
    input  logic             wrst_n,
    input  logic             cmd_valid,
    input  logic [LENW-1:0]  cmd_len,
    output logic             cmd_ready,
    input  logic             s_valid,
    input  logic [DSIZE-1:0] s_data,
    output logic             s_ready,
    output logic             winc,
    output logic [DSIZE-1:0] wdata,
    input  logic             wfull,
    output logic             busy,
    output logic             frame_done,
    output logic [SEQW-1:0]  seq
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HDR  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_TRL  = 2'd3;

    logic [1:0]       state;
    logic [LENW-1:0]  len_q;
    logic [LENW-1:0]  cnt;
    logic [DSIZE-1:0] csum;

    // NOTE: every register here is a plain flop, so all of them take the async reset;
    // a mid-frame reset therefore abandons the frame cleanly and restarts seq at 0.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state      <= ST_IDLE;
            seq        <= '0;
            cnt        <= '0;
            csum       <= '0;
            len_q      <= '0;
            frame_done <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        len_q <= cmd_len;
                        cnt   <= '0;
                        csum  <= '0;
                        state <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (!wfull) state <= (len_q != '0) ? ST_DATA : ST_TRL;
                end
                ST_DATA: begin
                    if (s_valid && !wfull) begin
                        csum <= csum ^ s_data;
                        cnt  <= cnt + 1'b1;
                        if (cnt == len_q - 1'b1) state <= ST_TRL;
                    end
                end
                ST_TRL: begin
                    if (!wfull) begin
                        seq        <= seq + 1'b1;
                        frame_done <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        cmd_ready = 1'b0;
        s_ready   = 1'b0;
        winc      = 1'b0;
        wdata     = '0;
        case (state)
            ST_IDLE: cmd_ready = 1'b1;
            ST_HDR: begin
                wdata = {seq, len_q};
                winc  = ~wfull;
            end
            ST_DATA: begin
                s_ready = ~wfull;
                winc    = s_valid & ~wfull;
                wdata   = s_data;
            end
            ST_TRL: begin
                wdata = csum;
                winc  = ~wfull;
            end
            default: ;
        endcase
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_async_fifo_frame_writer.sv
// Scoreboard bench for async_fifo_frame_writer: frames push expected FIFO words,
// a negedge monitor pops and compares every winc=1 cycle.
module tb_async_fifo_frame_writer;

    localparam int DSIZE = 16;
    localparam int LENW  = 8;
    localparam int SEQW  = DSIZE - LENW;

    logic             wclk = 1'b0;
    logic             wrst_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic [LENW-1:0]  cmd_len = '0;
    logic             cmd_ready;
    logic             s_valid = 1'b0;
    logic [DSIZE-1:0] s_data = '0;
    logic             s_ready;
    logic             winc;
    logic [DSIZE-1:0] wdata;
    logic             wfull = 1'b0;
    logic             busy;
    logic             frame_done;
    logic [SEQW-1:0]  seq;

    async_fifo_frame_writer #(.DSIZE(DSIZE), .LENW(LENW)) dut (
        .wclk(wclk), .wrst_n(wrst_n),
        .cmd_valid(cmd_valid), .cmd_len(cmd_len), .cmd_ready(cmd_ready),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .winc(winc), .wdata(wdata), .wfull(wfull),
        .busy(busy), .frame_done(frame_done), .seq(seq)
    );

    always #5 wclk = ~wclk;

    int cyc;
    always @(posedge wclk) cyc <= cyc + 1;

    int n_pass;
    int n_total;
    int fd_cyc;
    logic [DSIZE-1:0] sb [$];
    logic [DSIZE-1:0] payload [0:255];
    logic [SEQW-1:0]  exp_seq = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    always @(negedge wclk) begin : monitor
        logic [DSIZE-1:0] e;
        if (wrst_n && winc) begin
            if (sb.size() == 0) check("sb_underflow", 32'(sb.size()), 32'd1);
            else begin
                e = sb.pop_front();
                check("wdata", 32'(wdata), 32'(e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    // Runs one frame; abort_at>=0 stops after that many payload words without a trailer.
    task automatic run_frame(input int len, input bit toggle, input int stall_at,
                             input int abort_at, input bit b2b, input int exp_lat);
        logic [DSIZE-1:0] cs;
        int i, budget, t0, stall_left, nexp;
        bit cr_err, ph;
        cs = '0;
        cr_err = 1'b0;
        nexp = (abort_at >= 0) ? abort_at : len;
        sb.push_back({exp_seq, 8'(len)});
        for (int k = 0; k < nexp; k++) begin
            sb.push_back(payload[k]);
            cs ^= payload[k];
        end
        if (abort_at < 0) sb.push_back(cs);

        cmd_valid = 1'b1;
        cmd_len   = LENW'(len);
        budget = 0;
        while (!cmd_ready && budget < 50) begin
            @(posedge wclk); #1;
            budget++;
        end
        check("cmd_ready_at_issue", 32'(cmd_ready), 32'd1);
        @(posedge wclk); #1;
        t0 = cyc;
        cmd_valid = 1'b0;
        if (b2b) check("b2b_idle_gap", 32'(t0 - fd_cyc), 32'd1);

        i = 0; ph = 1'b1; stall_left = 4; budget = 0;
        while (i < nexp && budget < 2000) begin
            wfull = (i == stall_at) && (stall_left > 0);
            if (wfull) stall_left--;
            s_valid = toggle ? ph : 1'b1;
            s_data  = payload[i];
            @(negedge wclk);
            if (cmd_ready) cr_err = 1'b1;
            if (wfull) begin
                check("stall_winc", 32'(winc), 32'd0);
                check("stall_s_ready", 32'(s_ready), 32'd0);
            end
            if (s_valid && s_ready) i++;
            if (s_ready) ph = ~ph;
            @(posedge wclk); #1;
            budget++;
        end
        s_valid = 1'b0;
        wfull   = 1'b0;
        check("payload_words_taken", 32'(i), 32'(nexp));
        if (abort_at >= 0) return;

        budget = 0;
        forever begin
            @(negedge wclk);
            if (frame_done || budget >= 50) break;
            if (cmd_ready) cr_err = 1'b1;
            @(posedge wclk); #1;
            budget++;
        end
        fd_cyc = cyc;
        check("frame_done_seen", 32'(frame_done), 32'd1);
        check("cmd_ready_while_busy", 32'(cr_err), 32'd0);
        check("idle_after_frame", 32'({cmd_ready, busy}), 32'b10);
        if (exp_lat >= 0) check("frame_latency", 32'(cyc - t0), 32'(exp_lat));
        exp_seq++;
        check("seq", 32'(seq), 32'(exp_seq));
    endtask

    initial begin
        s_valid = 1'b1;
        #12;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_winc", 32'(winc), 32'd0);
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_wdata", 32'(wdata), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_seq", 32'(seq), 32'd0);
        @(posedge wclk); #1;
        wrst_n = 1'b1;
        @(posedge wclk); #1;
        check("idle_s_ready", 32'(s_ready), 32'd0);
        check("idle_winc", 32'(winc), 32'd0);
        s_valid = 1'b0;

        // Frame 1: header 0x0003, payload 11/22/44, trailer 0x0077.
        payload[0] = 16'h0011; payload[1] = 16'h0022; payload[2] = 16'h0044;
        run_frame(3, 1'b0, -1, -1, 1'b0, 5);

        // Empty frame: header {01,00}, trailer 0x0000.
        run_frame(0, 1'b0, -1, -1, 1'b1, 2);

        // Four-cycle wfull stall before the third payload word.
        payload[0] = 16'h1234; payload[1] = 16'hABCD; payload[2] = 16'h0F0F; payload[3] = 16'h8001;
        run_frame(4, 1'b0, 2, -1, 1'b0, -1);

        // s_valid toggling 1,0,1,0 during DATA.
        payload[0] = 16'hC001; payload[1] = 16'h0C02; payload[2] = 16'h00C4; payload[3] = 16'h8008;
        run_frame(4, 1'b1, -1, -1, 1'b0, -1);

        // Maximum length frame: cnt reaches 2^LENW-1 without overflowing.
        for (int k = 0; k < 256; k++) payload[k] = 16'(k * 16'h0101) ^ 16'h5A3C;
        run_frame(255, 1'b0, -1, -1, 1'b0, 257);

        // Advance seq to 0xFF, then 17 back-to-back single-word frames across the wrap.
        while (exp_seq != 8'hFF) run_frame(0, 1'b0, -1, -1, 1'b1, 2);
        for (int f = 0; f < 17; f++) begin
            payload[0] = 16'(f * 16'h1111 + 1);
            run_frame(1, 1'b0, -1, -1, 1'b1, 3);
        end

        // Reset after two payload words of a five-word frame.
        payload[0] = 16'hAAAA; payload[1] = 16'h5555;
        run_frame(5, 1'b0, -1, 2, 1'b0, -1);
        s_valid = 1'b1;
        s_data  = 16'hBEEF;
        wrst_n  = 1'b0;
        #1;
        check("midrst_winc", 32'(winc), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("midrst_seq", 32'(seq), 32'd0);
        @(posedge wclk); @(posedge wclk); #1;
        s_valid = 1'b0;
        wrst_n  = 1'b1;
        exp_seq = '0;
        check("sb_empty_after_abort", 32'(sb.size()), 32'd0);
        payload[0] = 16'h0707;
        run_frame(1, 1'b0, -1, -1, 1'b0, 3);

        repeat (3) @(posedge wclk);
        #1;
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
